// File: rtl/tt_sweep_pkg.sv
// Shared constants, FSM encoding and delay-line tag type for the truth-table sweeper.
package tt_sweep_pkg;

   localparam int N_IN       = 7;
   localparam int N_ROWS     = 128;
   localparam int MISMATCH_W = 8;

   // Index of the final row; the sweep stops issuing once it reaches this value.
   localparam logic [N_IN-1:0] LAST_IDX = 7'(N_ROWS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // One issued vector travelling alongside the network's evaluation latency.
   typedef struct packed {
      logic            valid;
      logic [N_IN-1:0] index;
   } tag_t;

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Bundle of the sweeper's control/result bus and the network-facing vector/output pair.
//
// Handshake: the host raises start (with expected_tt valid on the same cycle);
// it is taken only while busy=0 and done=0, i.e. in IDLE. busy stays high for
// the whole sweep, done pulses for one cycle with tt/match/mismatch_count valid,
// and those results hold until the next accepted start. start seen while a
// sweep is running is dropped, never queued. vec/fn_out carry no handshake:
// fn_out must reflect the vec presented a fixed EVAL_LAT cycles earlier.
interface tt_sweep_capture_if;
   import tt_sweep_pkg::*;

   logic                  start;
   logic [N_ROWS-1:0]     expected_tt;
   logic [N_IN-1:0]       vec;
   logic                  fn_out;
   logic                  busy;
   logic                  done;
   logic [N_ROWS-1:0]     tt;
   logic                  match;
   logic [MISMATCH_W-1:0] mismatch_count;

   modport master (
      output start, expected_tt, fn_out,
      input  vec, busy, done, tt, match, mismatch_count
   );

   modport slave (
      input  start, expected_tt, fn_out,
      output vec, busy, done, tt, match, mismatch_count
   );

endinterface

// File: rtl/sweep_delay_line.sv
// Delays the {valid, index} tag of each issued vector so it lines up with the
// network's output; depth 0 is a plain wire for combinational networks.
module sweep_delay_line
   import tt_sweep_pkg::*;
#(
   parameter int DEPTH = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  tag_t tag_in,
   output tag_t tag_out
);

   generate
      if (DEPTH == 0) begin : g_wire
         // Clock and reset have no job when there is nothing to register.
         logic unused_clk_rst;
         assign unused_clk_rst = clk & rst_n;
         assign tag_out = tag_in;
      end else begin : g_pipe
         tag_t stage_q [DEPTH];
         tag_t stage_d [DEPTH];

         // Shift each tag one stage further per cycle.
         always_comb begin
            stage_d[0] = tag_in;
            for (int k = 1; k < DEPTH; k++) begin
               stage_d[k] = stage_q[k-1];
            end
         end

         // Stage registers; reset empties the pipe so no stale capture can land.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int k = 0; k < DEPTH; k++) begin
                  stage_q[k] <= '0;
               end
            end else begin
               for (int k = 0; k < DEPTH; k++) begin
                  stage_q[k] <= stage_d[k];
               end
            end
         end

         assign tag_out = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all 128 input vectors of a 7-input network, captures each output bit
// into a truth table and scores it against a reference signature.
module tt_sweep_capture
   import tt_sweep_pkg::*;
#(
   parameter int EVAL_LAT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tt_sweep_capture_if.slave    bus,
   output state_t               dbg_state
);

   state_t                state_q, state_d;
   logic [N_IN-1:0]       cnt_q, cnt_d;
   logic [N_ROWS-1:0]     expected_q, expected_d;
   logic [N_ROWS-1:0]     tt_q, tt_d;
   logic                  match_q, match_d;
   logic [MISMATCH_W-1:0] mcount_q, mcount_d;

   tag_t issue_tag;
   tag_t cap_tag;
   logic last_lands;

   // Tag every vector issued during SWEEP with its row index.
   always_comb begin
      issue_tag       = '0;
      issue_tag.valid = (state_q == SWEEP);
      issue_tag.index = cnt_q;
   end

   sweep_delay_line #(
      .DEPTH (EVAL_LAT)
   ) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (issue_tag),
      .tag_out (cap_tag)
   );

   // Next-state, issue counter, capture and scoring.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      expected_d = expected_q;
      tt_d       = tt_q;
      match_d    = match_q;
      mcount_d   = mcount_q;
      last_lands = cap_tag.valid && (cap_tag.index == LAST_IDX);

      // A returning tag writes its row and scores it against the latched reference.
      if (cap_tag.valid) begin
         tt_d[cap_tag.index] = bus.fn_out;
         if (bus.fn_out != expected_q[cap_tag.index]) begin
            mcount_d = mcount_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.start) begin
               state_d    = SWEEP;
               expected_d = bus.expected_tt;
               tt_d       = '0;
               mcount_d   = '0;
               match_d    = 1'b0;
            end
         end
         SWEEP: begin
            if (cnt_q == LAST_IDX) begin
               cnt_d = '0;
               // With a combinational network the last row lands right now.
               state_d = last_lands ? DONE : DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (last_lands) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Settle match on the edge into DONE so it is valid alongside done.
      if ((state_d == DONE) && (state_q != DONE)) begin
         match_d = (tt_d == expected_q);
      end
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         expected_q <= '0;
         tt_q       <= '0;
         match_q    <= 1'b0;
         mcount_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         expected_q <= expected_d;
         tt_q       <= tt_d;
         match_q    <= match_d;
         mcount_q   <= mcount_d;
      end
   end

   assign bus.vec            = (state_q == SWEEP) ? cnt_q : '0;
   assign bus.busy           = (state_q == SWEEP) || (state_q == DRAIN);
   assign bus.done           = (state_q == DONE);
   assign bus.tt             = tt_q;
   assign bus.match          = match_q;
   assign bus.mismatch_count = mcount_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: a combinational-network instance (EVAL_LAT=0)
// and a 2-deep registered-network instance (EVAL_LAT=2) driven from directed
// sweeps, checked every cycle against a timeline/table model plus literal pins.
module tb_tt_sweep_capture;
   import tt_sweep_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs and networks ----------------
   tt_sweep_capture_if if0 ();
   tt_sweep_capture_if if2 ();
   state_t dbg0, dbg2;
   int     mode0 = 0;
   int     mode2 = 0;
   logic   p1_q = 1'b0;
   logic   p2_q = 1'b0;

   // Network under test: mode 0 = maj(x0,x1,x2), mode 1 = constant 1.
   function automatic logic net_f(input int mode, input logic [6:0] v);
      if (mode == 1) return 1'b1;
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   assign if0.fn_out = net_f(mode0, if0.vec);

   always @(posedge clk) begin
      p1_q <= net_f(mode2, if2.vec);
      p2_q <= p1_q;
   end
   assign if2.fn_out = p2_q;

   tt_sweep_capture #(.EVAL_LAT(0)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (if0),
      .dbg_state (dbg0)
   );

   tt_sweep_capture #(.EVAL_LAT(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (if2),
      .dbg_state (dbg2)
   );

   // ---------------- scoreboard ----------------
   int n_vec  = 0;
   int n_fail = 0;

   logic [127:0] exp_q0[$];
   logic [127:0] exp_q1[$];

   int           lat      [2] = '{0, 2};
   bit           act      [2] = '{0, 0};
   int           s_cyc    [2] = '{0, 0};
   logic [127:0] exp_lat  [2] = '{128'h0, 128'h0};
   logic [127:0] held_tt  [2] = '{128'h0, 128'h0};
   logic         held_m   [2] = '{1'b0, 1'b0};
   logic [7:0]   held_mc  [2] = '{8'h0, 8'h0};
   int           done_cnt [2] = '{0, 0};
   int           done_cyc [2] = '{0, 0};

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, want);
      end
   endtask

   function automatic logic [127:0] table_of(input int mode);
      logic [127:0] t;
      for (int i = 0; i < 128; i++) t[i] = net_f(mode, 7'(i));
      return t;
   endfunction

   // Check one DUT against the sweep timeline, then advance the model to the next cycle.
   task automatic cmp(input int d, input logic [6:0] vec, input logic busy, input logic done,
                      input logic [127:0] tt, input logic match, input logic [7:0] mc,
                      input logic start_in, input logic [127:0] exp_in, input int mode_in);
      int           rel;
      logic [6:0]   e_vec;
      logic         e_busy, e_done;
      bit           accept;
      logic [127:0] t;
      rel    = cyc - s_cyc[d];
      e_vec  = '0;
      e_busy = act[d] && rel >= 1 && rel <= 128 + lat[d];
      e_done = act[d] && rel == 129 + lat[d];
      if (act[d] && rel >= 1 && rel <= 128) e_vec = 7'(rel - 1);
      if (e_done) begin
         if (d == 0 && exp_q0.size() > 0) held_tt[d] = exp_q0.pop_front();
         if (d == 1 && exp_q1.size() > 0) held_tt[d] = exp_q1.pop_front();
         held_mc[d] = 8'($countones(held_tt[d] ^ exp_lat[d]));
         held_m[d]  = (held_tt[d] == exp_lat[d]);
      end
      chk($sformatf("d%0d_vec", d), 128'(vec), 128'(e_vec));
      chk($sformatf("d%0d_busy", d), 128'(busy), 128'(e_busy));
      chk($sformatf("d%0d_done", d), 128'(done), 128'(e_done));
      if (!e_busy) begin
         chk($sformatf("d%0d_tt", d), tt, held_tt[d]);
         chk($sformatf("d%0d_match", d), 128'(match), 128'(held_m[d]));
         chk($sformatf("d%0d_mismatch_count", d), 128'(mc), 128'(held_mc[d]));
      end
      if (done === 1'b1) begin
         done_cnt[d]++;
         done_cyc[d] = cyc;
      end
      accept = !act[d] && (start_in === 1'b1) && (rst_n === 1'b1);
      if (e_done) act[d] = 1'b0;
      if (rst_n !== 1'b1) begin
         act[d]     = 1'b0;
         held_tt[d] = '0;
         held_m[d]  = 1'b0;
         held_mc[d] = '0;
         if (d == 0) exp_q0.delete();
         else        exp_q1.delete();
      end else if (accept) begin
         act[d]     = 1'b1;
         s_cyc[d]   = cyc;
         exp_lat[d] = exp_in;
         held_tt[d] = '0;
         held_m[d]  = 1'b0;
         held_mc[d] = '0;
         t = table_of(mode_in);
         if (d == 0) exp_q0.push_back(t);
         else        exp_q1.push_back(t);
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= 1) begin
         cmp(0, if0.vec, if0.busy, if0.done, if0.tt, if0.match, if0.mismatch_count,
             if0.start, if0.expected_tt, mode0);
         cmp(1, if2.vec, if2.busy, if2.done, if2.tt, if2.match, if2.mismatch_count,
             if2.start, if2.expected_tt, mode2);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulse start on the combinational instance; returns with the bench in sweep cycle 1.
   task automatic start0(input int mode, input logic [127:0] e, output int s);
      mode0 = mode;
      if0.expected_tt = e;
      if0.start = 1'b1;
      s = cyc;
      tick(1);
      if0.start = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   logic [127:0] e8_tt;
   logic [127:0] flip5_tt;
   int           s0;
   int           dc;

   initial begin
      e8_tt    = {16{8'hE8}};
      flip5_tt = e8_tt ^ (128'h1 << 5);
      rst_n = 1'b0;
      if0.start = 1'b0; if0.expected_tt = '0;
      if2.start = 1'b0; if2.expected_tt = '0;
      tick(3);
      rst_n = 1'b1;
      tick(2);

      chk("reset_state0", 128'(dbg0), 128'(IDLE));
      chk("reset_state2", 128'(dbg2), 128'(IDLE));
      chk("reset_tt0", if0.tt, 128'h0);

      // Majority network, matching reference.
      start0(0, e8_tt, s0);
      tick(128);
      chk("t1_done", 128'(if0.done), 128'h1);
      chk("t1_tt", if0.tt, 128'he8e8e8e8e8e8e8e8e8e8e8e8e8e8e8e8);
      chk("t1_match", 128'(if0.match), 128'h1);
      chk("t1_mismatch_count", 128'(if0.mismatch_count), 128'h0);
      tick(2);
      chk("t1_done_cycle", 128'(done_cyc[0] - s0), 128'd129);

      // Majority network, reference with bit 5 flipped.
      start0(0, flip5_tt, s0);
      tick(128);
      chk("t2_mismatch_count", 128'(if0.mismatch_count), 128'h1);
      chk("t2_match", 128'(if0.match), 128'h0);
      chk("t2_tt_bit5", 128'(if0.tt[5]), 128'h1);
      tick(2);

      // Constant-1 network.
      start0(1, e8_tt, s0);
      tick(128);
      chk("t3_tt", if0.tt, {128{1'b1}});
      chk("t3_mismatch_count", 128'(if0.mismatch_count), 128'd64);
      chk("t3_match", 128'(if0.match), 128'h0);
      tick(2);

      // Two-deep registered majority network.
      mode2 = 0;
      if2.expected_tt = e8_tt;
      if2.start = 1'b1;
      s0 = cyc;
      tick(1);
      if2.start = 1'b0;
      tick(129);
      chk("t4_busy_130", 128'(if2.busy), 128'h1);
      chk("t4_done_130", 128'(if2.done), 128'h0);
      tick(1);
      chk("t4_done_131", 128'(if2.done), 128'h1);
      chk("t4_busy_131", 128'(if2.busy), 128'h0);
      chk("t4_tt", if2.tt, 128'he8e8e8e8e8e8e8e8e8e8e8e8e8e8e8e8);
      chk("t4_match", 128'(if2.match), 128'h1);
      tick(2);

      // Second start mid-sweep (with a different reference) must be ignored.
      dc = done_cnt[0];
      start0(0, e8_tt, s0);
      tick(49);
      if0.start = 1'b1;
      if0.expected_tt = '0;
      tick(1);
      if0.start = 1'b0;
      tick(78);
      chk("t5_done", 128'(if0.done), 128'h1);
      chk("t5_match", 128'(if0.match), 128'h1);
      chk("t5_tt", if0.tt, e8_tt);
      tick(3);
      chk("t5_done_pulses", 128'(done_cnt[0] - dc), 128'd1);

      // Reset in the middle of a sweep, then a fresh sweep.
      dc = done_cnt[0];
      start0(1, e8_tt, s0);
      tick(59);
      rst_n = 1'b0;
      tick(1);
      chk("t6_rst_busy", 128'(if0.busy), 128'h0);
      chk("t6_rst_vec", 128'(if0.vec), 128'h0);
      chk("t6_rst_tt", if0.tt, 128'h0);
      chk("t6_rst_mismatch_count", 128'(if0.mismatch_count), 128'h0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      chk("t6_after_tt", if0.tt, 128'h0);
      chk("t6_no_done", 128'(done_cnt[0] - dc), 128'd0);
      start0(0, e8_tt, s0);
      tick(140);
      chk("t6_new_done_cycle", 128'(done_cyc[0] - s0), 128'd129);
      chk("t6_new_tt", if0.tt, e8_tt);
      chk("t6_new_match", 128'(if0.match), 128'h1);

      tick(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
